// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one-at-a-time word fetches to instruction memory and
// buffers returned {instr, pc+4} pairs in a small circular FIFO feeding the IF/ID register.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;
  localparam logic [31:0]      RESET_ADDR = {RESET_PC[31:2], 2'b00};

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic              req_reg, req_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       target_reg, target_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc4_mem   [DEPTH];

  logic        ack_live;
  logic        push;
  logic        pop;
  logic [31:0] addr_plus4;
  logic [31:0] redirect_aligned;

  assign ack_live         = req_reg & imem_ack;
  assign addr_plus4       = addr_reg + 32'd4;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Redirect overrides both queue operations; responses during FLUSH are dropped.
  assign push = ack_live & (state_reg == FETCH) & ~redirect;
  assign pop  = out_valid & ~id_stall & ~redirect;

  always_comb begin
    state_next  = state_reg;
    req_next    = req_reg;
    addr_next   = addr_reg;
    target_next = target_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;

    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase

    if (redirect) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end

    case (state_reg)
      FETCH: begin
        if (redirect) begin
          if (req_reg && !imem_ack) begin
            // Old request must still complete before the target can be issued.
            state_next  = FLUSH;
            target_next = redirect_aligned;
          end else begin
            addr_next = redirect_aligned;
            req_next  = 1'b1;
          end
        end else if (ack_live) begin
          addr_next = addr_plus4;
          req_next  = (count_next < DEPTH_C);
        end else if (!req_reg) begin
          req_next = (count_next < DEPTH_C);
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          state_next = FETCH;
          addr_next  = redirect ? redirect_aligned : target_reg;
          req_next   = 1'b1;
        end else if (redirect) begin
          target_next = redirect_aligned;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FETCH;
      req_reg    <= 1'b0;
      addr_reg   <= RESET_ADDR;
      target_reg <= RESET_ADDR;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      req_reg    <= req_next;
      addr_reg   <= addr_next;
      target_reg <= target_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_data;
      pc4_mem[wr_ptr_reg]   <= addr_plus4;
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign out_valid = (count_reg != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign out_pc4   = out_valid ? pc4_mem[rd_ptr_reg]   : 32'h0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: stimulus pushes expected {instr, pc4} pairs,
// an independent monitor pops and compares each entry the DUT hands to IF/ID.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t sb[$];

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_stall   (id_stall),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc4    (out_pc4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_push(input logic [31:0] instr, input logic [31:0] pc4);
    entry_t e;
    e.instr = instr;
    e.pc4   = pc4;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; id_stall = 1'b0;
    sb.delete();
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every accepted head entry.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (out_valid) begin
        if (!id_stall && !redirect) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got instr %h pc4 %h expected no entry", out_instr, out_pc4);
          end else begin
            entry_t e;
            e = sb.pop_front();
            $display("pop instr=%h pc4=%h", out_instr, out_pc4);
            chk("pop_instr", out_instr, e.instr);
            chk("pop_pc4", out_pc4, e.pc4);
          end
        end
      end else begin
        chk("idle_instr", out_instr, 32'h0);
        chk("idle_pc4", out_pc4, 32'h0);
      end
    end
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    tick(); tick(); tick();
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_pc4", out_pc4, 32'h0);
    reset = 1'b0;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming: one ack per cycle, one output per cycle, one cycle behind.
    for (int i = 0; i < 6; i++) begin
      chk("stream_req", {31'b0, imem_req}, 32'd1);
      chk("stream_addr", imem_addr, 32'(4 * i));
      chk("stream_valid", {31'b0, out_valid}, (i != 0) ? 32'd1 : 32'd0);
      imem_ack  = 1'b1;
      imem_data = 32'h2008_0001 + 32'(i) * 32'h0001_0001;
      expect_push(imem_data, 32'(4 * (i + 1)));
      tick();
    end
    chk("stream_end_valid", {31'b0, out_valid}, 32'd1);
    chk("stream_end_addr", imem_addr, 32'h18);
    imem_ack = 1'b0;
    tick();
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // Full queue under stall.
    do_reset();
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_req", {31'b0, imem_req}, 32'd1);
      chk("fill_addr", imem_addr, 32'(4 * i));
      imem_ack  = 1'b1;
      imem_data = 32'hA000_0000 + 32'(i);
      expect_push(imem_data, 32'(4 * i + 4));
      tick();
    end
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_addr", imem_addr, 32'h10);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_head_instr", out_instr, 32'hA000_0000);
    chk("full_head_pc4", out_pc4, 32'h4);
    tick();
    chk("full_hold_req", {31'b0, imem_req}, 32'd0);
    chk("full_hold_addr", imem_addr, 32'h10);
    id_stall = 1'b0; imem_ack = 1'b0;
    tick();
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_data = 32'hB000_0000;
    expect_push(imem_data, 32'h14);
    tick();
    imem_ack = 1'b0;
    chk("resume_next_addr", imem_addr, 32'h14);
    repeat (5) tick();
    chk("fill_drained_valid", {31'b0, out_valid}, 32'd0);
    chk("fill_drained", 32'(sb.size()), 32'd0);

    // Redirect while a request is outstanding; ack arrives three cycles later.
    do_reset();
    imem_ack = 1'b1; imem_data = 32'hC000_0000;
    expect_push(imem_data, 32'h4);
    tick();
    chk("rd_addr4", imem_addr, 32'h4);
    imem_data = 32'hC000_0001;
    expect_push(imem_data, 32'h8);
    tick();
    chk("rd_addr8", imem_addr, 32'h8);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    sb.delete();
    tick();
    redirect = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_req", {31'b0, imem_req}, 32'd1);
    chk("flush_addr_hold", imem_addr, 32'h8);
    tick();
    chk("flush_addr_hold2", imem_addr, 32'h8);
    tick();
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("flush_done_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_done_req", {31'b0, imem_req}, 32'd1);
    chk("flush_target_addr", imem_addr, 32'h40);
    imem_ack = 1'b1; imem_data = 32'hC000_0004;
    expect_push(imem_data, 32'h44);
    tick();
    imem_ack = 1'b0;
    chk("target_out_pc4", out_pc4, 32'h44);
    chk("target_next_addr", imem_addr, 32'h44);

    // Redirect coincident with ack: data is dropped.
    imem_ack = 1'b1; imem_data = 32'hBADB_AD00;
    redirect = 1'b1; redirect_pc = 32'h80;
    sb.delete();
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("coinc_valid", {31'b0, out_valid}, 32'd0);
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h80);
    tick();
    chk("coinc_valid2", {31'b0, out_valid}, 32'd0);

    // Two redirects during FLUSH; the later (misaligned) target wins.
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("flush2_addr_hold", imem_addr, 32'h80);
    redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b1; imem_data = 32'h5555_5555;
    tick();
    imem_ack = 1'b0;
    chk("latest_wins_addr", imem_addr, 32'h200);
    chk("latest_wins_valid", {31'b0, out_valid}, 32'd0);
    imem_ack = 1'b1; imem_data = 32'hF000_0000;
    expect_push(imem_data, 32'h204);
    tick();
    imem_ack = 1'b0;
    chk("latest_next_addr", imem_addr, 32'h204);

    // Redirect to the top word: pc4 and next fetch wrap to zero.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_data = 32'h7777_7777;
    sb.delete();
    tick();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_data = 32'hE000_0000;
    expect_push(imem_data, 32'h0);
    tick();
    imem_ack = 1'b0;
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_valid", {31'b0, out_valid}, 32'd1);
    chk("wrap_pc4", out_pc4, 32'h0);
    tick();

    // Reset with three entries queued and a request pending.
    do_reset();
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ack  = 1'b1;
      imem_data = 32'h9000_0000 + 32'(i);
      tick();
    end
    imem_ack = 1'b0;
    chk("pre_rst_addr", imem_addr, 32'hC);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    sb.delete();
    tick();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'h0);
    imem_ack = 1'b1; imem_data = 32'h6666_6666;
    tick();
    chk("rst_ack_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b0; imem_ack = 1'b0; id_stall = 1'b0;
    tick();
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_valid", {31'b0, out_valid}, 32'd0);
    imem_ack = 1'b1; imem_data = 32'h1234_5678;
    expect_push(imem_data, 32'h4);
    tick();
    imem_ack = 1'b0;
    tick(); tick();
    chk("final_drained", 32'(sb.size()), 32'd0);
    chk("final_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of 2, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  registered instruction-memory read request.
REQ-006 imem_addr  output  32  registered fetch address, word aligned.
REQ-007 imem_ack  input  1  memory returns imem_data this cycle and completes the request.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 redirect  input  1  taken branch from MEM stage; flush and refetch.
REQ-010 redirect_pc  input  32  branch target.
REQ-011 id_stall  input  1  IF/ID register cannot accept this cycle.
REQ-012 out_valid  output  1  head entry presented to the IF/ID register.
REQ-013 out_instr  output  32  head instruction; 32'h0 (nop) when out_valid=0.
REQ-014 out_pc4  output  32  head fetch address + 4; 32'h0 when out_valid=0.

Function
REQ-015 Block SHALL sit between instruction memory and the IF/ID register, holding up to DEPTH {instr, pc4} pairs in a circular FIFO.
REQ-016 At most one memory request SHALL be outstanding; imem_req and imem_addr SHALL hold stable from assertion until the cycle imem_ack=1.
REQ-017 A new request SHALL be issued only when count < DEPTH; with space it SHALL issue the cycle after the previous ack, allowing one ack per cycle.
REQ-018 On imem_ack in state FETCH: push {imem_data, imem_addr+4}; next fetch address = imem_addr+4, mod 2^32 (32'hFFFFFFFC wraps to 0).
REQ-019 Pop SHALL occur when out_valid=1 and id_stall=0; head SHALL advance next cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; a push to an empty queue SHALL make out_valid=1 the next cycle, so ack-to-output latency is 1 cycle.
REQ-021 out_valid SHALL equal (count != 0); outputs SHALL be driven from the head entry with no combinational path from imem_data.
REQ-022 FSM states: FETCH (normal), FLUSH (discard the in-flight response).
REQ-023 redirect=1 SHALL take priority over push and pop: count<=0, read and write pointers reset, fetch PC <= {redirect_pc[31:2], 2'b00}.
REQ-024 redirect with a request outstanding and imem_ack=0: enter FLUSH, keep imem_req high on the old address, then on ack discard data and request the redirect target next cycle, returning to FETCH.
REQ-025 redirect in the same cycle as imem_ack: discard imem_data, stay in FETCH, request the redirect target next cycle.
REQ-026 redirect while in FLUSH SHALL update only the pending target PC; the latest redirect_pc SHALL win.
REQ-027 out_valid SHALL be 0 in the cycle after any redirect.
REQ-028 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-029 While reset=1: count=0, pointers=0, state=FETCH, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc4=0.
REQ-030 The first cycle after reset deasserts SHALL drive imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset mid-request SHALL abandon the request and discard any ack seen during reset.

Verification
REQ-032 Reset, then ack every cycle with data 0x20080001, 0x20090002, and so on, id_stall=0 -> outputs appear one per cycle, 1 cycle after each ack; out_pc4 = 4, 8, 12, ...
REQ-033 id_stall=1 held, DEPTH=4, ack always high -> exactly 4 pushes, then imem_req=0 and imem_addr=0x10; release id_stall -> requests resume at 0x10.
REQ-034 redirect=1, redirect_pc=0x40 while a request to 0x08 is pending, ack 3 cycles later -> data discarded, out_valid=0, next imem_addr=0x40, first output out_pc4=0x44.
REQ-035 redirect coincident with imem_ack -> ack data never appears at the output; next request is to redirect_pc.
REQ-036 redirect_pc=0xFFFFFFFC -> fetched entry has out_pc4=0x00000000; next imem_addr=0x00000000.
REQ-037 Assert reset with 3 entries queued and a request pending -> next cycle out_valid=0 and imem_req=0; after release, fetch restarts at RESET_PC.
